// File: rtl/pulse_timing_gen.sv
// Multi-channel pulse timing generator: a free-running or one-shot period counter
// with per-channel compare windows and wrap-synchronised configuration updates.
module pulse_timing_gen #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DEF_PERIOD = 5000
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          oneshot,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          cfg_period,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   cfg_on,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   cfg_off,
    input  logic                          cfg_load,
    output logic [CNT_WIDTH-1:0]          cnt_value,
    output logic                          zero,
    output logic [NUM_CH-1:0]             ch_out,
    output logic                          busy,
    output logic                          cfg_pending
);

    localparam int unsigned CFG_W = NUM_CH * CNT_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic                   mode_os;
    logic [CNT_WIDTH-1:0]   act_period;
    logic [CFG_W-1:0]       act_on;
    logic [CFG_W-1:0]       act_off;
    logic [CNT_WIDTH-1:0]   stg_period;
    logic [CFG_W-1:0]       stg_on;
    logic [CFG_W-1:0]       stg_off;

    logic                   wrap_c;
    logic                   start_req_c;
    logic [NUM_CH-1:0]      win_c;

    // Plain, wrap-around or empty window depending on the order of on/off.
    function automatic logic in_window(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [CNT_WIDTH-1:0] on_v,
        input logic [CNT_WIDTH-1:0] off_v
    );
        logic hit;
        hit = 1'b0;
        if (on_v < off_v) begin
            hit = (cnt >= on_v) && (cnt < off_v);
        end else if (on_v > off_v) begin
            hit = (cnt >= on_v) || (cnt < off_v);
        end
        return hit;
    endfunction

    always_comb begin
        wrap_c      = (cnt_value >= act_period);
        start_req_c = oneshot ? start : enable;
        win_c       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            win_c[i] = in_window(cnt_value,
                                 act_on[i*CNT_WIDTH +: CNT_WIDTH],
                                 act_off[i*CNT_WIDTH +: CNT_WIDTH]);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_os     <= 1'b0;
            cnt_value   <= '0;
            zero        <= 1'b0;
            ch_out      <= '0;
            busy        <= 1'b0;
            cfg_pending <= 1'b0;
            act_period  <= CNT_WIDTH'(DEF_PERIOD);
            act_on      <= '0;
            act_off     <= '0;
            stg_period  <= '0;
            stg_on      <= '0;
            stg_off     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_value   <= '0;
                    zero        <= 1'b0;
                    ch_out      <= '0;
                    cfg_pending <= 1'b0;
                    if (cfg_load) begin
                        act_period <= cfg_period;
                        act_on     <= cfg_on;
                        act_off    <= cfg_off;
                    end
                    if (start_req_c) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        mode_os <= oneshot;
                    end
                end
                ST_RUN: begin
                    zero   <= (cnt_value == '0);
                    ch_out <= win_c;
                    if (wrap_c) begin
                        // New config (fresh load wins over staged) takes effect as the count restarts.
                        cnt_value   <= '0;
                        cfg_pending <= 1'b0;
                        if (cfg_load) begin
                            act_period <= cfg_period;
                            act_on     <= cfg_on;
                            act_off    <= cfg_off;
                        end else if (cfg_pending) begin
                            act_period <= stg_period;
                            act_on     <= stg_on;
                            act_off    <= stg_off;
                        end
                        if (mode_os || !enable) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt_value <= cnt_value + CNT_WIDTH'(1);
                        if (cfg_load) begin
                            stg_period  <= cfg_period;
                            stg_on      <= cfg_on;
                            stg_off     <= cfg_off;
                            cfg_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_timing_gen.sv
// Self-checking bench for pulse_timing_gen: vector table plus scoreboarded sequences.
module tb_pulse_timing_gen;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        enable;
    logic        oneshot;
    logic        start;
    logic [15:0] cfg_period;
    logic [63:0] cfg_on;
    logic [63:0] cfg_off;
    logic        cfg_load;
    logic [15:0] cnt_value;
    logic        zero;
    logic [3:0]  ch_out;
    logic        busy;
    logic        cfg_pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic [15:0] cnt;
        logic        z;
        logic [3:0]  ch;
        logic        b;
        logic        p;
    } exp_t;

    typedef struct {
        logic        en;
        logic [15:0] cnt;
        logic        z;
        logic [3:0]  ch;
        logic        b;
    } vec_t;

    exp_t       sb[$];
    vec_t       tab[43];
    logic [3:0] win[10];

    pulse_timing_gen dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .enable      (enable),
        .oneshot     (oneshot),
        .start       (start),
        .cfg_period  (cfg_period),
        .cfg_on      (cfg_on),
        .cfg_off     (cfg_off),
        .cfg_load    (cfg_load),
        .cnt_value   (cnt_value),
        .zero        (zero),
        .ch_out      (ch_out),
        .busy        (busy),
        .cfg_pending (cfg_pending)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // Push the expectation for the next edge, clock once, then pop and compare.
    task automatic cyc(input string nm, input logic [15:0] c, input logic z,
                       input logic [3:0] ch, input logic b, input logic p);
        exp_t e;
        e.nm = nm; e.cnt = c; e.z = z; e.ch = ch; e.b = b; e.p = p;
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        e = sb.pop_front();
        chk({e.nm, ".cnt"},  32'(cnt_value),   32'(e.cnt));
        chk({e.nm, ".zero"}, 32'(zero),        32'(e.z));
        chk({e.nm, ".ch"},   32'(ch_out),      32'(e.ch));
        chk({e.nm, ".busy"}, 32'(busy),        32'(e.b));
        chk({e.nm, ".pend"}, 32'(cfg_pending), 32'(e.p));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".cnt"},  32'(cnt_value),   32'd0);
        chk({nm, ".zero"}, 32'(zero),        32'd0);
        chk({nm, ".ch"},   32'(ch_out),      32'd0);
        chk({nm, ".busy"}, 32'(busy),        32'd0);
        chk({nm, ".pend"}, 32'(cfg_pending), 32'd0);
    endtask

    initial begin
        // Channel windows for P=9: ch0 2/5, ch1 8/2 (wrap), ch2 4/4 (empty), ch3 3/15.
        win[0] = 4'b0010; win[1] = 4'b0010; win[2] = 4'b0001; win[3] = 4'b1001;
        win[4] = 4'b1001; win[5] = 4'b1000; win[6] = 4'b1000; win[7] = 4'b1000;
        win[8] = 4'b1010; win[9] = 4'b1010;

        for (int k = 0; k < 43; k++) begin
            tab[k].en  = (k <= 32);
            tab[k].cnt = (k <= 39) ? 16'(k % 10) : 16'd0;
            tab[k].z   = (k >= 1 && k <= 40 && ((k - 1) % 10) == 0);
            tab[k].ch  = (k == 0 || k > 40) ? 4'b0000 : win[(k - 1) % 10];
            tab[k].b   = (k <= 39);
        end

        rst = 1'b1; enable = 1'b0; oneshot = 1'b0; start = 1'b0; cfg_load = 1'b0;
        cfg_period = 16'd0; cfg_on = '0; cfg_off = '0;
        #3;
        chk_all_zero("reset");
        @(posedge clk_in); #1;
        rst = 1'b0;
        cyc("idle", 0, 0, 0, 0, 0);

        // Continuous run with windows, then graceful stop after enable drops at count 2.
        cfg_period = 16'd9;
        cfg_on  = {16'd3, 16'd4, 16'd8, 16'd2};
        cfg_off = {16'd15, 16'd4, 16'd2, 16'd5};
        cfg_load = 1'b1;
        cyc("load_idle", 0, 0, 0, 0, 0);
        cfg_load = 1'b0;
        for (int k = 0; k < 43; k++) begin
            enable = tab[k].en;
            cyc($sformatf("tab%0d", k), tab[k].cnt, tab[k].z, tab[k].ch, tab[k].b, 1'b0);
        end

        // Staged load, overwrite while pending, then load coincident with a wrap.
        enable = 1'b1;
        cyc("stg_start", 0, 0, 0, 1, 0);
        for (int c = 1; c <= 3; c++) cyc("stg_run", 16'(c), (c == 1), win[c-1], 1, 0);
        cfg_period = 16'd6; cfg_load = 1'b1;
        cyc("stg_ld1", 4, 0, win[3], 1, 1);
        cfg_load = 1'b0;
        cyc("stg_pend5", 5, 0, win[4], 1, 1);
        cfg_period = 16'd4; cfg_load = 1'b1;
        cyc("stg_ld2", 6, 0, win[5], 1, 1);
        cfg_load = 1'b0;
        for (int c = 7; c <= 9; c++) cyc("stg_pend", 16'(c), 0, win[c-1], 1, 1);
        cyc("stg_wrap", 0, 0, win[9], 1, 0);
        for (int c = 1; c <= 4; c++) cyc("stg_p4", 16'(c), (c == 1), win[c-1], 1, 0);
        cfg_period = 16'd9; cfg_load = 1'b1;
        cyc("stg_coinc", 0, 0, win[4], 1, 0);
        cfg_load = 1'b0;
        for (int c = 1; c <= 5; c++) cyc("stg_p9", 16'(c), (c == 1), win[c-1], 1, 0);
        enable = 1'b0;
        for (int c = 6; c <= 9; c++) cyc("stg_stop", 16'(c), 0, win[c-1], 1, 0);
        cyc("stg_idle", 0, 0, win[9], 0, 0);
        cyc("stg_idle2", 0, 0, 0, 0, 0);

        // One-shot of P+1 cycles; enable alone and a mid-run start are both ignored.
        oneshot = 1'b1; cfg_period = 16'd6; cfg_load = 1'b1;
        cyc("os_load", 0, 0, 0, 0, 0);
        cfg_load = 1'b0; enable = 1'b1;
        cyc("os_noen", 0, 0, 0, 0, 0);
        enable = 1'b0; start = 1'b1;
        cyc("os_s", 0, 0, 0, 1, 0);
        start = 1'b0;
        for (int c = 1; c <= 3; c++) cyc("os_run", 16'(c), (c == 1), win[c-1], 1, 0);
        start = 1'b1;
        cyc("os_restart", 4, 0, win[3], 1, 0);
        start = 1'b0;
        for (int c = 5; c <= 6; c++) cyc("os_run", 16'(c), 0, win[c-1], 1, 0);
        cyc("os_end", 0, 0, win[6], 0, 0);
        cyc("os_idle", 0, 0, 0, 0, 0);

        // P = 0: every cycle is a wrap.
        oneshot = 1'b0; cfg_period = 16'd0; cfg_load = 1'b1;
        cyc("p0_load", 0, 0, 0, 0, 0);
        cfg_load = 1'b0; enable = 1'b1;
        cyc("p0_s", 0, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) cyc("p0_run", 0, 1, win[0], 1, 0);
        enable = 1'b0;
        cyc("p0_stop", 0, 1, win[0], 0, 0);
        cyc("p0_idle", 0, 0, 0, 0, 0);
        oneshot = 1'b1; start = 1'b1;
        cyc("p0_os", 0, 0, 0, 1, 0);
        start = 1'b0;
        cyc("p0_os_end", 0, 1, win[0], 0, 0);
        oneshot = 1'b0;

        // Asynchronous reset mid-period, then default period is back in force.
        cfg_period = 16'd9; cfg_load = 1'b1;
        cyc("rs_load", 0, 0, 0, 0, 0);
        cfg_load = 1'b0; enable = 1'b1;
        cyc("rs_s", 0, 0, 0, 1, 0);
        for (int c = 1; c <= 5; c++) cyc("rs_run", 16'(c), (c == 1), win[c-1], 1, 0);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("rs_async");
        @(posedge clk_in); #1;
        chk_all_zero("rs_hold");
        enable = 1'b0;
        rst = 1'b0;
        cyc("rs_idle", 0, 0, 0, 0, 0);
        cyc("rs_idle2", 0, 0, 0, 0, 0);
        enable = 1'b1;
        cyc("rs_run0", 0, 0, 0, 1, 0);
        for (int c = 1; c <= 5000; c++) cyc("rs_def", 16'(c), (c == 1), 0, 1, 0);
        cyc("rs_wrap", 0, 0, 0, 1, 0);
        cyc("rs_after", 1, 1, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
